// File: rtl/cmd_sequencer.sv
// Feeds CPU cmdin from a DEPTH-slot command buffer, holding each command for ISSUE_CYCLES cycles.
// Latency: start at edge k -> command i on cmd_out from cycle k+1+i*ISSUE_CYCLES; done at k+1+N*ISSUE_CYCLES.
// Backpressure: load_ready deasserts when the buffer is full or the sequencer is not IDLE.
module cmd_sequencer #(
    parameter int         DEPTH        = 8,
    parameter int         ISSUE_CYCLES = 4,
    parameter logic [6:0] NOP_CMD      = 7'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic [6:0]                 load_cmd,
    output logic                       load_ready,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cpu_error,
    input  logic                       cpu_zero,
    output logic [6:0]                 cmd_out,
    output logic                       cmd_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       halted,
    output logic                       last_zero,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(ISSUE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [6:0]      slot [DEPTH];
    logic [WW-1:0]   win_q;
    logic            load_fire;
    logic            ctl_open;
    logic            run_active;
    logic            win_last;
    logic            last_cmd;
    logic [CW-1:0]   eff_count;

    // IDLE and HALT are the only states that accept clear/start
    assign ctl_open   = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign run_active = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign load_ready = (state_q == ST_IDLE) && (count < CW'(DEPTH));
    assign load_fire  = load_valid && load_ready;
    // a load landing with start is part of the run, so judge emptiness on the post-load count
    assign eff_count  = count + CW'(load_fire);
    assign win_last   = (win_q == WW'(ISSUE_CYCLES - 1));
    assign last_cmd   = ({1'b0, pc} == (count - CW'(1)));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; clear beats start, abort beats the end-of-window decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = (eff_count == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = abort ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (win_last) begin
                    if (cpu_error) begin
                        state_d = ST_HALT;
                    end else if (last_cmd) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from state so an async reset reaches them immediately
    always_comb begin
        cmd_out   = NOP_CMD;
        cmd_valid = 1'b0;
        busy      = run_active;
        done      = (state_q == ST_DONE);
        halted    = (state_q == ST_HALT);
        if (run_active) begin
            cmd_out = slot[pc];
        end
        if (state_q == ST_ISSUE) begin
            cmd_valid = 1'b1;
        end
    end

    // Command buffer storage; contents are meaningless until loaded, so no reset
    always_ff @(posedge clk) begin
        if (load_fire) begin
            slot[count[PW-1:0]] <= load_cmd;
        end
    end

    // Count, program counter, window counter and zero-flag capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            pc        <= '0;
            win_q     <= '0;
            last_zero <= 1'b0;
        end else begin
            if (ctl_open && clear) begin
                count <= '0;
            end else if (load_fire) begin
                count <= count + CW'(1);
            end

            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (clear || start) begin
                        pc <= '0;
                    end
                end
                ST_ISSUE: begin
                    win_q <= WW'(1);
                    if (abort) begin
                        pc <= '0;
                    end
                end
                ST_WAIT: begin
                    win_q <= win_q + WW'(1);
                    if (abort) begin
                        pc <= '0;
                    end else if (win_last) begin
                        last_zero <= cpu_zero;
                        if (!cpu_error && !last_cmd) begin
                            pc <= pc + PW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    pc <= '0;
                end
                default: begin
                    pc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with hand-computed cycle-by-cycle expectations.
// Cycle c of a run is the c-th clock period after the edge that samples start.
// Inputs change 1ns after a rising edge; outputs are observed at the same point.
module tb_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int IC    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [6:0] load_cmd = 7'd0;
    logic       load_ready;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cpu_error = 1'b0;
    logic       cpu_zero = 1'b0;
    logic [6:0] cmd_out;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       halted;
    logic       last_zero;
    logic [2:0] pc;
    logic [3:0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] prog [3];

    cmd_sequencer #(.DEPTH(DEPTH), .ISSUE_CYCLES(IC), .NOP_CMD(7'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_cmd   (load_cmd),
        .load_ready (load_ready),
        .clear      (clear),
        .start      (start),
        .abort      (abort),
        .cpu_error  (cpu_error),
        .cpu_zero   (cpu_zero),
        .cmd_out    (cmd_out),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .halted     (halted),
        .last_zero  (last_zero),
        .pc         (pc),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [6:0] w);
        load_valid = 1'b1;
        load_cmd   = w;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Walk cycles 1..3*IC+1 of a three-command error-free run and end in cycle 3*IC+2
    task automatic check_full_run(input string tag, input logic exp_lz);
        logic [6:0] ecmd;
        logic       ev, eb, ed;
        for (int c = 1; c <= 3 * IC + 1; c++) begin
            ecmd = (c <= 3 * IC) ? prog[(c - 1) / IC] : 7'd0;
            ev   = (c <= 3 * IC) && (((c - 1) % IC) == 0);
            eb   = (c <= 3 * IC);
            ed   = (c == 3 * IC + 1);
            if ({cmd_out, cmd_valid, busy, done} !== {ecmd, ev, eb, ed}) begin
                $display("FAIL %s cyc%0d cmd/vld/busy/done got %h/%b/%b/%b want %h/%b/%b/%b",
                         tag, c, cmd_out, cmd_valid, busy, done, ecmd, ev, eb, ed);
                miscompares++;
            end
            vectors++;
            step();
        end
        if ({done, load_ready, pc, last_zero} !== {1'b0, 1'b1, 3'd0, exp_lz}) begin
            $display("FAIL %s post done/load_ready/pc/last_zero got %b/%b/%0d/%b want 0/1/0/%b",
                     tag, done, load_ready, pc, last_zero, exp_lz);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_reset();
        #2;
        if ({cmd_out, cmd_valid, busy, done, halted, last_zero} !== 12'b0) begin
            $display("FAIL reset_outputs got cmd=%h vld=%b busy=%b done=%b halt=%b lz=%b want all 0",
                     cmd_out, cmd_valid, busy, done, halted, last_zero);
            miscompares++;
        end
        vectors++;
        if ({load_ready, count, pc} !== {1'b1, 4'd0, 3'd0}) begin
            $display("FAIL reset_ctl got load_ready=%b count=%0d pc=%0d want 1/0/0",
                     load_ready, count, pc);
            miscompares++;
        end
        vectors++;
        #4;
        rst = 1'b1;
        step();
    endtask

    task automatic test_load_full();
        for (int i = 0; i < DEPTH; i++) begin
            load_word(7'(8'h60 + i));
        end
        if ({load_ready, count} !== {1'b0, 4'd8}) begin
            $display("FAIL load_full got load_ready=%b count=%0d want 0/8", load_ready, count);
            miscompares++;
        end
        vectors++;
        load_word(7'h7F);
        if (count !== 4'd8) begin
            $display("FAIL load_overflow got count=%0d want 8", count);
            miscompares++;
        end
        vectors++;
        do_clear();
        if ({load_ready, count} !== {1'b1, 4'd0}) begin
            $display("FAIL clear_idle got load_ready=%b count=%0d want 1/0", load_ready, count);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_load3();
        prog[0] = 7'h11;
        prog[1] = 7'h22;
        prog[2] = 7'h33;
        for (int i = 0; i < 3; i++) begin
            load_word(prog[i]);
        end
        if ({load_ready, count} !== {1'b1, 4'd3}) begin
            $display("FAIL load3 got load_ready=%b count=%0d want 1/3", load_ready, count);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_normal_run();
        cpu_zero = 1'b1;
        pulse_start();
        check_full_run("normal_run", 1'b1);
        cpu_zero = 1'b0;
    endtask

    task automatic test_error_halt();
        logic [6:0] ecmd;
        logic       ev;
        pulse_start();
        for (int c = 1; c <= 2 * IC; c++) begin
            cpu_error = (c > IC);
            ecmd = prog[(c - 1) / IC];
            ev   = (((c - 1) % IC) == 0);
            if ({cmd_out, cmd_valid, busy} !== {ecmd, ev, 1'b1}) begin
                $display("FAIL err_run cyc%0d cmd/vld/busy got %h/%b/%b want %h/%b/1",
                         c, cmd_out, cmd_valid, busy, ecmd, ev);
                miscompares++;
            end
            vectors++;
            step();
        end
        cpu_error = 1'b0;
        if ({halted, pc, cmd_out, busy, done} !== {1'b1, 3'd1, 7'd0, 1'b0, 1'b0}) begin
            $display("FAIL err_halt got halted=%b pc=%0d cmd=%h busy=%b done=%b want 1/1/00/0/0",
                     halted, pc, cmd_out, busy, done);
            miscompares++;
        end
        vectors++;
        for (int c = 0; c < 6; c++) begin
            step();
            if ({halted, cmd_out, cmd_valid} !== {1'b1, 7'd0, 1'b0}) begin
                $display("FAIL err_hold cyc%0d got halted=%b cmd=%h vld=%b want 1/00/0",
                         c, halted, cmd_out, cmd_valid);
                miscompares++;
            end
            vectors++;
        end
        pulse_start();
        if ({halted, pc, cmd_out, cmd_valid} !== {1'b0, 3'd0, 7'h11, 1'b1}) begin
            $display("FAIL err_rerun got halted=%b pc=%0d cmd=%h vld=%b want 0/0/11/1",
                     halted, pc, cmd_out, cmd_valid);
            miscompares++;
        end
        vectors++;
        for (int c = 1; c <= 3 * IC; c++) begin
            step();
        end
        if ({done, halted} !== 2'b10) begin
            $display("FAIL err_rerun_done got done=%b halted=%b want 1/0", done, halted);
            miscompares++;
        end
        vectors++;
        step();
    endtask

    task automatic test_abort();
        int saw_done;
        saw_done = 0;
        pulse_start();
        for (int c = 1; c <= 6; c++) begin
            abort = (c == 6);
            step();
        end
        abort = 1'b0;
        if ({cmd_out, busy, done} !== {7'd0, 1'b0, 1'b0}) begin
            $display("FAIL abort_now got cmd=%h busy=%b done=%b want 00/0/0", cmd_out, busy, done);
            miscompares++;
        end
        vectors++;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) saw_done++;
            step();
        end
        if (saw_done !== 0) begin
            $display("FAIL abort_quiet got %0d busy/done cycles want 0", saw_done);
            miscompares++;
        end
        vectors++;
        if ({count, pc, load_ready} !== {4'd3, 3'd0, 1'b1}) begin
            $display("FAIL abort_state got count=%0d pc=%0d load_ready=%b want 3/0/1",
                     count, pc, load_ready);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_empty_start();
        do_clear();
        pulse_start();
        if ({done, busy, cmd_out} !== {1'b1, 1'b0, 7'd0}) begin
            $display("FAIL empty_done got done=%b busy=%b cmd=%h want 1/0/00", done, busy, cmd_out);
            miscompares++;
        end
        vectors++;
        step();
        if ({done, busy} !== 2'b00) begin
            $display("FAIL empty_after got done=%b busy=%b want 0/0", done, busy);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_clear_start();
        load_word(7'h55);
        load_word(7'h56);
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        if ({count, busy, done} !== {4'd0, 1'b0, 1'b0}) begin
            $display("FAIL clear_start got count=%0d busy=%b done=%b want 0/0/0", count, busy, done);
            miscompares++;
        end
        vectors++;
        step();
        if ({busy, done, cmd_out} !== {1'b0, 1'b0, 7'd0}) begin
            $display("FAIL clear_start_after got busy=%b done=%b cmd=%h want 0/0/00",
                     busy, done, cmd_out);
            miscompares++;
        end
        vectors++;
    endtask

    task automatic test_load_start();
        prog[0] = 7'h41;
        prog[1] = 7'h42;
        prog[2] = 7'h43;
        load_word(prog[0]);
        load_word(prog[1]);
        load_valid = 1'b1;
        load_cmd   = prog[2];
        start      = 1'b1;
        step();
        load_valid = 1'b0;
        start      = 1'b0;
        if (count !== 4'd3) begin
            $display("FAIL load_start_count got %0d want 3", count);
            miscompares++;
        end
        vectors++;
        check_full_run("load_start", 1'b0);
    endtask

    task automatic test_async_reset();
        pulse_start();
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        if ({cmd_out, cmd_valid, busy, done, halted, last_zero} !== 12'b0) begin
            $display("FAIL arst_outputs got cmd=%h vld=%b busy=%b done=%b halt=%b lz=%b want all 0",
                     cmd_out, cmd_valid, busy, done, halted, last_zero);
            miscompares++;
        end
        vectors++;
        if ({count, pc} !== {4'd0, 3'd0}) begin
            $display("FAIL arst_ctl got count=%0d pc=%0d want 0/0", count, pc);
            miscompares++;
        end
        vectors++;
        #2;
        rst = 1'b1;
        step();
        if ({count, load_ready, busy} !== {4'd0, 1'b1, 1'b0}) begin
            $display("FAIL arst_release got count=%0d load_ready=%b busy=%b want 0/1/0",
                     count, load_ready, busy);
            miscompares++;
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_load_full();
        test_load3();
        test_normal_run();
        test_error_halt();
        test_abort();
        test_empty_start();
        test_clear_start();
        test_load_start();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
